// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Sends sequential word fetches to instruction memory, keeps in-order
// responses in a small FIFO and hands {inst, inst_pc} to the decoder over
// a valid/ready handshake. A redirect flushes buffered words and arranges
// for in-flight responses to be discarded.
// Optional build macro: FETCH_BYPASS_EN -- a response arriving while the
// FIFO is empty and nothing is being dropped is presented in the same cycle.
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// clock edge where valid and ready are both 1; a request held with ready=0
// keeps valid and its payload stable until it transfers or a redirect
// withdraws it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [31:0]    fetch_pc;
    logic [31:0]    resp_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop;
    logic [CW-1:0]  count;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [31:0]    fifo_inst [DEPTH];
    logic [31:0]    fifo_pc   [DEPTH];

    logic [CW:0]    credit_used;
    logic [31:0]    target_pc;
    logic           req_fire;
    logic           resp_keep;
    logic           resp_discard;
    logic           fifo_empty;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           unused_pc_bits;

    // Redirect targets are forced to word alignment; low bits are ignored.
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // State register: BOOT for the first cycle after reset, then RUN forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // Request credit, response classification, FIFO control and decoder outputs.
    always_comb begin
        credit_used    = {1'b0, outstanding} + {1'b0, count};
        imem_req_valid = (state == RUN) && !redirect &&
                         (credit_used < (CW + 1)'(DEPTH));
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_keep      = imem_resp_valid && (drop == '0);
        resp_discard   = imem_resp_valid && (drop != '0);
        fifo_empty     = (count == '0);
`ifdef FETCH_BYPASS_EN
        bypass         = fifo_empty && resp_keep;
`else
        bypass         = 1'b0;
`endif
        inst_valid     = !fifo_empty || bypass;
        inst           = bypass ? imem_resp_data : fifo_inst[rd_ptr];
        inst_pc        = bypass ? resp_pc        : fifo_pc[rd_ptr];
        pop            = !fifo_empty && inst_ready;
        // A bypassed word taken by the decoder never enters the FIFO;
        // nothing is stored on a redirect cycle.
        push           = resp_keep && !redirect && !(bypass && inst_ready);
    end

    // Instruction FIFO storage and pointers; a redirect empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= NOP;
                fifo_pc[i]   <= RESET_PC;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr] <= imem_resp_data;
                fifo_pc[wr_ptr]   <= resp_pc;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Outstanding-request and drop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect) begin
                // Everything still in flight belongs to the old path; a
                // response landing this same cycle is already gone.
                drop <= outstanding - CW'(imem_resp_valid);
            end else if (resp_discard) begin
                drop <= drop - CW'(1);
            end
        end
    end

    // Fetch and response PC counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A bench-side memory answers accepted requests in order after a random
// latency with a word derived from the address. The reference model is the
// architectural instruction stream: consecutive PCs from the reset PC,
// restarting at each redirect target; every word the decoder takes and
// every accepted request address is compared against it.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          req_rdy_pct;
    int          inst_rdy_pct;
    int          resp_pct;
    int          lat_min;
    int          lat_max;
    logic [31:0] pend_addr_q[$];
    int          pend_due_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] cons_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          first_valid_cyc;
    bit          auto_armed;
    bit          auto_fired;
    logic [31:0] auto_target;
    int          redir_cons_idx;
    int          redir_acc_idx;
    int          n_consumed;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Hold reset for two edges, release on a falling edge, restart the model.
    task automatic do_reset();
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        pend_addr_q.delete();
        pend_due_q.delete();
        acc_q.delete();
        cons_q.delete();
        prev_hold  = 1'b0;
        auto_armed = 1'b0;
        auto_fired = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst             = 1'b0;
        cyc             = 0;
        exp_pc          = RESET_PC;
        exp_req_pc      = RESET_PC;
        first_valid_cyc = -1;
    endtask

    // One clock cycle: drive memory/decoder/redirect inputs at the falling
    // edge, then check the handshakes that will complete at the next rising edge.
    task automatic tick(input bit redir, input logic [31:0] rpc);
        bit          do_redir;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc &&
            $urandom_range(0, 99) < resp_pct) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr_q[0]);
            void'(pend_addr_q.pop_front());
            void'(pend_due_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 99) < req_rdy_pct);
        inst_ready     = ($urandom_range(0, 99) < inst_rdy_pct);
        redirect       = 1'b0;
        redirect_pc    = $urandom;
        #1;
        do_redir = redir;
        tgt      = rpc;
        if (auto_armed && inst_valid && inst_ready && imem_resp_valid) begin
            do_redir   = 1'b1;
            tgt        = auto_target;
            auto_armed = 1'b0;
            auto_fired = 1'b1;
        end
        if (do_redir) begin
            redirect    = 1'b1;
            redirect_pc = tgt;
            #1;
        end
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_hold && !do_redir) begin
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                n_fail++;
                $display("FAIL req_hold cyc=%0d: valid=%b addr=%h, required valid=1 addr=%h",
                         cyc, imem_req_valid, imem_req_addr, prev_addr);
            end
        end
        if (do_redir) begin
            n_tests++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL req_on_redirect cyc=%0d: valid=%b, required 0", cyc, imem_req_valid);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            n_tests++;
            if (imem_req_addr !== exp_req_pc) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d: addr=%h, required %h", cyc, imem_req_addr, exp_req_pc);
            end
            acc_q.push_back(imem_req_addr);
            pend_addr_q.push_back(imem_req_addr);
            pend_due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (inst_valid && inst_ready) begin
            n_tests++;
            if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL inst_stream cyc=%0d: pc=%h inst=%h, required pc=%h inst=%h",
                         cyc, inst_pc, inst, exp_pc, mem_word(exp_pc));
            end
            cons_q.push_back(inst_pc);
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
        if (do_redir) begin
            exp_pc         = {tgt[31:2], 2'b00};
            exp_req_pc     = {tgt[31:2], 2'b00};
            redir_cons_idx = cons_q.size();
            redir_acc_idx  = acc_q.size();
        end
        prev_hold = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
    endtask

    task automatic set_ideal(input int lat);
        req_rdy_pct  = 100;
        inst_rdy_pct = 100;
        resp_pct     = 100;
        lat_min      = lat;
        lat_max      = lat;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        #2;
        n_tests++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_req: valid=%b addr=%h, required 0 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        n_tests++;
        if (inst_valid !== 1'b0 || inst !== NOP || inst_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_inst: valid=%b inst=%h pc=%h, required 0 %h %h",
                     inst_valid, inst, inst_pc, NOP, RESET_PC);
        end
        do_reset();
        #1;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_no_req: valid=%b, required 0", imem_req_valid);
        end
    endtask

    task automatic test_sequential();
        set_ideal(1);
        do_reset();
        repeat (12) tick(1'b0, 32'h0);
        n_tests++;
`ifdef FETCH_BYPASS_EN
        if (first_valid_cyc != 2) begin
            n_fail++;
            $display("FAIL first_valid_cycle: got %0d, required 2", first_valid_cyc);
        end
`else
        if (first_valid_cyc != 3) begin
            n_fail++;
            $display("FAIL first_valid_cycle: got %0d, required 3", first_valid_cyc);
        end
`endif
        exp_q = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (acc_q.size() <= i || acc_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL seq_req[%0d]: got %h (n=%0d), required %h", i,
                         (acc_q.size() > i) ? acc_q[i] : 32'hx, acc_q.size(), exp_q[i]);
            end
            n_tests++;
            if (cons_q.size() <= i || cons_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL seq_inst[%0d]: got %h (n=%0d), required %h", i,
                         (cons_q.size() > i) ? cons_q[i] : 32'hx, cons_q.size(), exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_ideal(1);
        inst_rdy_pct = 0;
        do_reset();
        repeat (10) tick(1'b0, 32'h0);
        n_tests++;
        if (acc_q.size() != DEPTH || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_stall: requests=%0d valid=%b, required %0d and 0",
                     acc_q.size(), imem_req_valid, DEPTH);
        end
        n_tests++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL credit_head: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, RESET_PC);
        end
        inst_rdy_pct = 100;
        repeat (10) tick(1'b0, 32'h0);
        exp_q = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (cons_q.size() <= i || cons_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_inst[%0d]: got %h (n=%0d), required %h", i,
                         (cons_q.size() > i) ? cons_q[i] : 32'hx, cons_q.size(), exp_q[i]);
            end
        end
        n_tests++;
        if (acc_q.size() < 3 || acc_q[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL resume_req: n=%0d, required third request at 00000008", acc_q.size());
        end
    endtask

    task automatic test_req_stall();
        set_ideal(1);
        req_rdy_pct = 0;
        do_reset();
        repeat (4) tick(1'b0, 32'h0);
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL mem_stall: valid=%b addr=%h accepted=%0d, required 1 %h 0",
                     imem_req_valid, imem_req_addr, acc_q.size(), RESET_PC);
        end
        req_rdy_pct = 100;
        repeat (3) tick(1'b0, 32'h0);
        n_tests++;
        if (acc_q.size() < 2 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4) begin
            n_fail++;
            $display("FAIL stall_release: n=%0d, required requests 00000000,00000004", acc_q.size());
        end
    endtask

    task automatic test_redirect();
        set_ideal(3);
        do_reset();
        repeat (2) tick(1'b0, 32'h0);
        tick(1'b1, 32'h100);
        acc_q.delete();
        cons_q.delete();
        repeat (20) tick(1'b0, 32'h0);
        n_tests++;
        if (acc_q.size() < 2 || acc_q[0] !== 32'h100 || acc_q[1] !== 32'h104) begin
            n_fail++;
            $display("FAIL redirect_req: n=%0d first=%h, required 00000100,00000104",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 32'hx);
        end
        n_tests++;
        if (cons_q.size() < 1 || cons_q[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_inst: n=%0d first=%h, required 00000100",
                     cons_q.size(), (cons_q.size() > 0) ? cons_q[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_pop();
        set_ideal(1);
        do_reset();
        auto_target = 32'h103;
        auto_armed  = 1'b1;
        repeat (15) tick(1'b0, 32'h0);
        n_tests++;
        if (auto_fired !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_pop_setup: no pop+response cycle seen, required one");
        end else begin
            n_tests++;
            if (redir_cons_idx < 1 || cons_q.size() <= redir_cons_idx ||
                cons_q[redir_cons_idx] !== 32'h100) begin
                n_fail++;
                $display("FAIL redirect_pop_inst: idx=%0d n=%0d, required popped word then 00000100",
                         redir_cons_idx, cons_q.size());
            end
            n_tests++;
            if (acc_q.size() <= redir_acc_idx || acc_q[redir_acc_idx] !== 32'h100) begin
                n_fail++;
                $display("FAIL redirect_pop_req: n=%0d, required next request 00000100", acc_q.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        set_ideal(3);
        do_reset();
        repeat (2) tick(1'b0, 32'h0);
        tick(1'b1, 32'h200);
        tick(1'b1, 32'h300);
        acc_q.delete();
        cons_q.delete();
        repeat (20) tick(1'b0, 32'h0);
        n_tests++;
        if (acc_q.size() < 1 || acc_q[0] !== 32'h300 || cons_q.size() < 1 || cons_q[0] !== 32'h300) begin
            n_fail++;
            $display("FAIL b2b_redirect: req=%h inst=%h, required 00000300 both",
                     (acc_q.size() > 0) ? acc_q[0] : 32'hx, (cons_q.size() > 0) ? cons_q[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        set_ideal(1);
        do_reset();
        tick(1'b1, 32'hFFFF_FFFC);
        acc_q.delete();
        cons_q.delete();
        repeat (10) tick(1'b0, 32'h0);
        n_tests++;
        if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_req: n=%0d, required fffffffc then 00000000", acc_q.size());
        end
        n_tests++;
        if (cons_q.size() < 2 || cons_q[0] !== 32'hFFFF_FFFC || cons_q[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_inst: n=%0d, required fffffffc then 00000000", cons_q.size());
        end
    endtask

    task automatic test_async_reset();
        req_rdy_pct  = 85;
        inst_rdy_pct = 80;
        resp_pct     = 85;
        lat_min      = 1;
        lat_max      = 3;
        do_reset();
        repeat (15) tick(1'b0, 32'h0);
        #2;
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        #1;
        n_tests++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst_pc !== RESET_PC || inst !== NOP) begin
            n_fail++;
            $display("FAIL async_reset: inst_valid=%b req_valid=%b pc=%h inst=%h, required 0 0 %h %h",
                     inst_valid, imem_req_valid, inst_pc, inst, RESET_PC, NOP);
        end
        set_ideal(1);
        do_reset();
        repeat (8) tick(1'b0, 32'h0);
        n_tests++;
        if (acc_q.size() < 1 || acc_q[0] !== RESET_PC || cons_q.size() < 1 || cons_q[0] !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart_after_reset: n_req=%0d n_inst=%0d, required both starting at %h",
                     acc_q.size(), cons_q.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        req_rdy_pct  = 70;
        inst_rdy_pct = 65;
        resp_pct     = 75;
        lat_min      = 1;
        lat_max      = 4;
        do_reset();
        n_consumed = 0;
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 99) < 4, $urandom);
        end
        set_ideal(2);
        repeat (30) tick(1'b0, 32'h0);
        n_tests++;
        if (n_consumed < 60) begin
            n_fail++;
            $display("FAIL random_progress: consumed %0d, required at least 60", n_consumed);
        end
    endtask

    // Bound the whole run.
    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_consumed = 0;
        cyc        = 0;
        set_ideal(1);
        test_reset();
        test_sequential();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
